// File: rtl/mac_pkg.sv
// mac_pkg: shared types and helpers for the MAC vector engine.
// Holds the stage bundle, accumulator bound helpers and a parameter legality test.
package mac_pkg;

    // Payload width of the shared stage bundle.
    // Each stage uses the low bits it needs.
    localparam int DW = 64;

    typedef struct packed {
        logic          valid;
        logic          last;
        logic [DW-1:0] data;
    } stage_t;

    // Largest accumulator value, as an acc_w-bit pattern in the low bits.
    function automatic logic [DW-1:0] acc_max(int acc_w, bit is_signed);
        logic [DW-1:0] r;
        if (is_signed)
            r = (64'd1 << (acc_w - 1)) - 64'd1;
        else if (acc_w >= DW)
            r = '1;
        else
            r = (64'd1 << acc_w) - 64'd1;
        return r;
    endfunction

    // Smallest accumulator value, as an acc_w-bit pattern in the low bits.
    function automatic logic [DW-1:0] acc_min(int acc_w, bit is_signed);
        logic [DW-1:0] r;
        if (is_signed)
            r = 64'd1 << (acc_w - 1);
        else
            r = '0;
        return r;
    endfunction

    function automatic bit acc_w_ok(int in_w, int acc_w);
        return (acc_w >= 2 * in_w) && (acc_w <= DW);
    endfunction

endpackage

// File: rtl/mac_vec_engine_if.sv
// mac_vec_engine_if: operand stream in, dot-product result stream out.
// Ports: in_valid/in_ready/in_a/in_b/in_last, out_valid/out_ready/out_data/out_ovf.
interface mac_vec_engine_if #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 40
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_a;
    logic [IN_W-1:0]  in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/mac_sat_add.sv
// mac_sat_add: combinational acc + prod with overflow detect and optional clamp.
// Ports: i_acc, i_prod (ACC_W) in; o_sum (ACC_W), o_ovf out.
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int ACC_W  = 40,
    parameter bit SIGNED = 1'b1,
    parameter bit SAT    = 1'b1
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [ACC_W-1:0] i_prod,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);
    localparam logic [ACC_W-1:0] MAX = ACC_W'(acc_max(ACC_W, SIGNED));
    localparam logic [ACC_W-1:0] MIN = ACC_W'(acc_min(ACC_W, SIGNED));

    logic [ACC_W:0] w_raw;
    logic           w_ovf;

    assign w_raw = {1'b0, i_acc} + {1'b0, i_prod};

    always_comb begin
        if (SIGNED)
            w_ovf = (i_acc[ACC_W-1] == i_prod[ACC_W-1]) &&
                    (w_raw[ACC_W-1] != i_acc[ACC_W-1]);
        else
            w_ovf = w_raw[ACC_W];
        o_ovf = w_ovf;
        o_sum = w_raw[ACC_W-1:0];
        // Signed overflow only happens with equal signs, so acc sign picks the rail.
        if (SAT && w_ovf)
            o_sum = (SIGNED && i_acc[ACC_W-1]) ? MIN : MAX;
    end
endmodule

// File: rtl/mac_vec_engine.sv
// mac_vec_engine: 3-stage pipelined MAC, one dot product per in_last-terminated vector.
// Ports: clk, rst_n (sync, active-low), s_io (slave side of mac_vec_engine_if).
module mac_vec_engine
    import mac_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int ACC_W  = 40,
    parameter bit SIGNED = 1'b1,
    parameter bit SAT    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mac_vec_engine_if.slave      s_io
);
    if (!acc_w_ok(IN_W, ACC_W)) begin : g_bad_params
        $error("mac_vec_engine: need 2*IN_W <= ACC_W <= 64");
    end

    localparam int PW = 2 * IN_W;
    // Bits above the product, set when sign-extending a negative product.
    localparam logic [ACC_W-1:0] HI = ~ACC_W'({PW{1'b1}});

    stage_t           r_s1;
    stage_t           r_s2;
    stage_t           r_s3;
    logic [ACC_W-1:0] r_acc;
    logic             r_sticky;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_data;
    logic             r_out_ovf;

    logic             w_adv;
    logic [IN_W-1:0]  w_a;
    logic [IN_W-1:0]  w_b;
    logic [PW-1:0]    w_a_ext;
    logic [PW-1:0]    w_b_ext;
    logic [PW-1:0]    w_prod;
    logic [PW-1:0]    w_p2;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_sum;
    logic             w_add_ovf;
    logic             w_unused;

    // The whole pipeline freezes while a result waits downstream.
    assign w_adv          = ~(r_out_valid & ~s_io.out_ready);
    assign s_io.in_ready  = w_adv;
    assign s_io.out_valid = r_out_valid;
    assign s_io.out_data  = r_out_data;
    assign s_io.out_ovf   = r_out_ovf;

    assign w_a = r_s1.data[PW-1:IN_W];
    assign w_b = r_s1.data[IN_W-1:0];

    // Low PW bits of the product of PW-bit extended operands give
    // the exact signed or unsigned product.
    assign w_a_ext = SIGNED ? {{IN_W{w_a[IN_W-1]}}, w_a} : {{IN_W{1'b0}}, w_a};
    assign w_b_ext = SIGNED ? {{IN_W{w_b[IN_W-1]}}, w_b} : {{IN_W{1'b0}}, w_b};
    assign w_prod  = w_a_ext * w_b_ext;

    assign w_p2  = r_s2.data[PW-1:0];
    assign w_ext = ACC_W'(w_p2) | ((SIGNED && w_p2[PW-1]) ? HI : '0);

    // Upper payload bits of the generic stage bundle carry nothing.
    assign w_unused = ^{r_s1.data, r_s2.data, r_s3.data};

    mac_sat_add #(
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED),
        .SAT    (SAT)
    ) u_add (
        .i_acc  (r_acc),
        .i_prod (r_s3.data[ACC_W-1:0]),
        .o_sum  (w_sum),
        .o_ovf  (w_add_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_s3        <= '0;
            r_acc       <= '0;
            r_sticky    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_adv) begin
            r_s1.valid <= s_io.in_valid;
            r_s1.last  <= s_io.in_last;
            r_s1.data  <= DW'({s_io.in_a, s_io.in_b});
            r_s2.valid <= r_s1.valid;
            r_s2.last  <= r_s1.last;
            r_s2.data  <= DW'(w_prod);
            r_s3.valid <= r_s2.valid;
            r_s3.last  <= r_s2.last;
            r_s3.data  <= DW'(w_ext);
            // Advancing with a valid result means out_ready is high.
            r_out_valid <= 1'b0;
            if (r_s3.valid) begin
                if (r_s3.last) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_sum;
                    r_out_ovf   <= r_sticky | w_add_ovf;
                    r_acc       <= '0;
                    r_sticky    <= 1'b0;
                end else begin
                    r_acc    <= w_sum;
                    r_sticky <= r_sticky | w_add_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_vec_engine.sv
// tb_mac_vec_engine: directed checks of four engine configurations driven in lockstep.
// uns: unsigned 40b, sgn: signed 40b, s32: signed 32b clamp, w32: signed 32b wrap.
module tb_mac_vec_engine;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mac_vec_engine_if #(.IN_W(16), .ACC_W(40)) if_uns ();
    mac_vec_engine_if #(.IN_W(16), .ACC_W(40)) if_sgn ();
    mac_vec_engine_if #(.IN_W(16), .ACC_W(32)) if_s32 ();
    mac_vec_engine_if #(.IN_W(16), .ACC_W(32)) if_w32 ();

    mac_vec_engine #(.IN_W(16), .ACC_W(40), .SIGNED(1'b0), .SAT(1'b1))
        u_uns (.clk(clk), .rst_n(rst_n), .s_io(if_uns));
    mac_vec_engine #(.IN_W(16), .ACC_W(40), .SIGNED(1'b1), .SAT(1'b1))
        u_sgn (.clk(clk), .rst_n(rst_n), .s_io(if_sgn));
    mac_vec_engine #(.IN_W(16), .ACC_W(32), .SIGNED(1'b1), .SAT(1'b1))
        u_s32 (.clk(clk), .rst_n(rst_n), .s_io(if_s32));
    mac_vec_engine #(.IN_W(16), .ACC_W(32), .SIGNED(1'b1), .SAT(1'b0))
        u_w32 (.clk(clk), .rst_n(rst_n), .s_io(if_w32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic l);
        if_uns.in_valid = v; if_uns.in_a = a; if_uns.in_b = b; if_uns.in_last = l;
        if_sgn.in_valid = v; if_sgn.in_a = a; if_sgn.in_b = b; if_sgn.in_last = l;
        if_s32.in_valid = v; if_s32.in_a = a; if_s32.in_b = b; if_s32.in_last = l;
        if_w32.in_valid = v; if_w32.in_a = a; if_w32.in_b = b; if_w32.in_last = l;
    endtask

    task automatic set_ready(input logic r);
        if_uns.out_ready = r;
        if_sgn.out_ready = r;
        if_s32.out_ready = r;
        if_w32.out_ready = r;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        set_ready(1'b1);
        drive(1'b0, 16'd0, 16'd0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_valid", 64'(if_sgn.out_valid), 64'd0);
        chk("rst_data", 64'(if_sgn.out_data), 64'd0);
        chk("rst_ovf", 64'(if_sgn.out_ovf), 64'd0);
        chk("rst_ready", 64'(if_sgn.in_ready), 64'd1);
        chk("rst_data32", 64'(if_s32.out_data), 64'd0);

        // Unsigned 3*4 + 5*6
        drive(1'b1, 16'd3, 16'd4, 1'b0); tick();
        drive(1'b1, 16'd5, 16'd6, 1'b1); tick();
        drive(1'b0, 16'd0, 16'd0, 1'b0); tick(); tick();
        chk("t1_latency", 64'(if_uns.out_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(if_uns.out_valid), 64'd1);
        chk("t1_data", 64'(if_uns.out_data), 64'd42);
        chk("t1_ovf", 64'(if_uns.out_ovf), 64'd0);
        tick();
        chk("t1_drop", 64'(if_uns.out_valid), 64'd0);

        // Signed -2*7 + 3*3
        drive(1'b1, 16'hFFFE, 16'd7, 1'b0); tick();
        drive(1'b1, 16'd3, 16'd3, 1'b1); tick();
        drive(1'b0, 16'd0, 16'd0, 1'b0); tick(); tick(); tick();
        chk("t2_valid", 64'(if_sgn.out_valid), 64'd1);
        chk("t2_sdata", 64'(if_sgn.out_data), 64'h00FF_FFFF_FFFB);
        chk("t2_sovf", 64'(if_sgn.out_ovf), 64'd0);
        chk("t2_udata", 64'(if_uns.out_data), 64'h6FFFB);
        tick();

        // 3 x 0x7FFF^2 overflows 32 bits
        drive(1'b1, 16'h7FFF, 16'h7FFF, 1'b0); tick();
        drive(1'b1, 16'h7FFF, 16'h7FFF, 1'b0); tick();
        drive(1'b1, 16'h7FFF, 16'h7FFF, 1'b1); tick();
        drive(1'b0, 16'd0, 16'd0, 1'b0); tick(); tick(); tick();
        chk("t3_sat_data", 64'(if_s32.out_data), 64'h7FFF_FFFF);
        chk("t3_sat_ovf", 64'(if_s32.out_ovf), 64'd1);
        chk("t3_wrap_data", 64'(if_w32.out_data), 64'hBFFD_0003);
        chk("t3_wrap_ovf", 64'(if_w32.out_ovf), 64'd1);
        chk("t3_wide_data", 64'(if_sgn.out_data), 64'hBFFD_0003);
        chk("t3_wide_ovf", 64'(if_sgn.out_ovf), 64'd0);
        tick();

        // Adds continue from the clamped value
        drive(1'b1, 16'h7FFF, 16'h7FFF, 1'b0); tick();
        drive(1'b1, 16'h7FFF, 16'h7FFF, 1'b0); tick();
        drive(1'b1, 16'h7FFF, 16'h7FFF, 1'b0); tick();
        drive(1'b1, 16'hFFFF, 16'd1, 1'b1); tick();
        drive(1'b0, 16'd0, 16'd0, 1'b0); tick(); tick(); tick();
        chk("t3b_sat_data", 64'(if_s32.out_data), 64'h7FFF_FFFE);
        chk("t3b_sat_ovf", 64'(if_s32.out_ovf), 64'd1);
        chk("t3b_wrap_data", 64'(if_w32.out_data), 64'hBFFD_0002);
        chk("t3b_wide_data", 64'(if_sgn.out_data), 64'hBFFD_0002);
        tick();

        // Back-to-back single-beat vectors
        drive(1'b1, 16'd2, 16'd2, 1'b1); tick();
        drive(1'b1, 16'd3, 16'd3, 1'b1); tick();
        drive(1'b1, 16'd4, 16'd4, 1'b1); tick();
        drive(1'b0, 16'd0, 16'd0, 1'b0); tick();
        chk("t4_v0", 64'(if_sgn.out_valid), 64'd1);
        chk("t4_d0", 64'(if_sgn.out_data), 64'd4);
        chk("t4_ovf_clr", 64'(if_s32.out_ovf), 64'd0);
        tick();
        chk("t4_v1", 64'(if_sgn.out_valid), 64'd1);
        chk("t4_d1", 64'(if_sgn.out_data), 64'd9);
        tick();
        chk("t4_v2", 64'(if_sgn.out_valid), 64'd1);
        chk("t4_d2", 64'(if_sgn.out_data), 64'd16);
        chk("t4_ovf2", 64'(if_sgn.out_ovf), 64'd0);
        tick();
        chk("t4_end", 64'(if_sgn.out_valid), 64'd0);

        // Backpressure: five stalled edges
        drive(1'b1, 16'd1, 16'd5, 1'b1); tick();
        drive(1'b1, 16'd2, 16'd5, 1'b1); tick();
        drive(1'b1, 16'd3, 16'd5, 1'b1); tick();
        drive(1'b1, 16'd4, 16'd5, 1'b1); tick();
        chk("t5_first", 64'(if_sgn.out_data), 64'd5);
        set_ready(1'b0);
        drive(1'b1, 16'd5, 16'd5, 1'b1);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t5_stall_ready", 64'(if_sgn.in_ready), 64'd0);
            chk("t5_stall_valid", 64'(if_sgn.out_valid), 64'd1);
            chk("t5_stall_data", 64'(if_sgn.out_data), 64'd5);
            tick();
        end
        chk("t5_hold_data", 64'(if_uns.out_data), 64'd5);
        set_ready(1'b1);
        #1;
        chk("t5_release", 64'(if_sgn.in_ready), 64'd1);
        tick();
        drive(1'b0, 16'd0, 16'd0, 1'b0);
        chk("t5_r2", 64'(if_sgn.out_data), 64'd10);
        chk("t5_r2v", 64'(if_sgn.out_valid), 64'd1);
        tick();
        chk("t5_r3", 64'(if_sgn.out_data), 64'd15);
        tick();
        chk("t5_r4", 64'(if_sgn.out_data), 64'd20);
        tick();
        chk("t5_r5", 64'(if_sgn.out_data), 64'd25);
        chk("t5_r5v", 64'(if_sgn.out_valid), 64'd1);
        tick();
        chk("t5_end", 64'(if_sgn.out_valid), 64'd0);

        // Reset discards a partial vector
        drive(1'b1, 16'd9, 16'd9, 1'b0); tick();
        drive(1'b1, 16'd9, 16'd9, 1'b0); tick();
        drive(1'b0, 16'd0, 16'd0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_valid", 64'(if_sgn.out_valid), 64'd0);
        chk("t6_ovf", 64'(if_sgn.out_ovf), 64'd0);
        chk("t6_ready", 64'(if_sgn.in_ready), 64'd1);
        drive(1'b1, 16'd1, 16'd1, 1'b1); tick();
        drive(1'b0, 16'd0, 16'd0, 1'b0); tick(); tick();
        chk("t6_latency", 64'(if_sgn.out_valid), 64'd0);
        tick();
        chk("t6_valid2", 64'(if_sgn.out_valid), 64'd1);
        chk("t6_data", 64'(if_sgn.out_data), 64'd1);
        chk("t6_data_uns", 64'(if_uns.out_data), 64'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
